hack_alu_pipe: RTL and testbench
================================

Name: hack_alu_pipe

Overview:
- Pipelined, parametrised successor to the combinational Hack ALU.
- Implements the same 6-bit {zx,nx,zy,ny,f,no} function set at configurable width.
- Adds an elastic valid/ready pipeline, a signed-overflow flag and an optional post-ALU shift stage.
- Sits between the CPU operand path and the writeback/flag logic; lets a future multi-cycle CPU register ALU results and apply backpressure.

Parameters:
- WIDTH, 16, datapath width in bits (≥4).
- STAGES, 2, pipeline depth: 1 (single output register) or 2 (pre-process register + output register).
- EXT_EN, 1, enables ext_op shifts; when 0, ext_op is ignored and treated as 2'b00.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/ctrl bundle valid.
- in_ready  out  1  pipeline can accept this cycle.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- ctrl  in  6  {zx,nx,zy,ny,f,no}, bit 5 = zx.
- ext_op  in  2  00 none, 01 shl1, 10 sra1, 11 srl1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  WIDTH  result.
- zr  out  1  out == 0.
- ng  out  1  out[WIDTH-1].
- ov  out  1  signed overflow of the add.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid bits, out, zr, ng and ov are cleared to 0 immediately; in_ready=1 while held. No state survives reset.
- Transfer rules:
  - Input accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - out, zr, ng, ov are registered and held stable while out_valid=1 & out_ready=0.
- Elastic pipeline:
  - Stage k loads when empty or when its contents advance in the same cycle.
  - in_ready = !v1 | advance1, a combinational function of valid bits and out_ready only.
  - No combinational path from in_valid to out_valid.
- Latency: STAGES cycles from accept to out_valid with out_ready held high. Throughput: 1 result per cycle.
- Ordering: strict in-order; no drop or duplicate under any backpressure pattern.
- Capacity: STAGES in-flight bundles. With out_ready=0, in_ready drops once all stages are full.
- Stage 1 (STAGES=2):
  - xp = nx ? ~(zx ? 0 : x) : (zx ? 0 : x); yp likewise with zy/ny.
  - Register xp, yp, f, no, ext_op.
- Stage 2 (or the single stage when STAGES=1):
  - r = f ? xp+yp (mod 2^WIDTH) : xp&yp; r = no ? ~r : r.
  - Shift: shl1 → {r[W-2:0],0}; sra1 → {r[W-1],r[W-1:1]}; srl1 → {0,r[W-1:1]}.
  - zr and ng are computed on the final shifted value.
- ov: f & (xp[W-1]==yp[W-1]) & (sum[W-1]!=xp[W-1]), computed on the raw sum before no/shift; 0 when f=0.
- Undefined ctrl codes: none. All 64 codes follow the equations above, so random ctrl values match the Hack reference model.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle.
- Reset mid-stream: in-flight bundles are discarded; out_valid=0 on the first edge after reset release.
- in_valid is ignored while rst_n=0.

Decomposition:
- Package hack_alu_pkg:
  - ctrl bit-index constants ZX..NO.
  - ext_op enum {EXT_NONE, EXT_SHL, EXT_SRA, EXT_SRL}.
  - The 18 canonical Hack ctrl codes as named constants: C_ZERO=101010, C_ONE=111111, C_NEG1=111010, C_X=001100, C_Y=110000, C_NOTX=001101, C_NOTY=110001, C_NEGX=001111, C_NEGY=110011, C_XP1=011111, C_YP1=110111, C_XM1=001110, C_YM1=110010, C_ADD=000010, C_XMY=010011, C_YMX=000111, C_AND=000000, C_OR=010101.
- Sub-module hack_alu_core: purely combinational, WIDTH-parametrised f/no/shift/flag logic. It is instantiated once; the pipeline wrapper owns all registers and handshakes.

Test Plan (WIDTH=16, STAGES=2, EXT_EN=1):
- Reset: rst_n=0 with in_valid=1 → out_valid=0, out=0, zr=0, ng=0, ov=0, in_ready=1; after release, first accepted op appears exactly 2 cycles later.
- C_ADD, x=16'h7FFF, y=16'h0001, ext 00 → out=16'h8000, ng=1, zr=0, ov=1.
- C_XMY, x=5, y=5 → out=0, zr=1, ng=0, ov=0. Then C_OR, x=16'hFFFF, y=0 → out=16'hFFFF, ng=1.
- C_Y, y=16'h8004 with ext 10/11/01 → 16'hC002 / 16'h4002 / 16'h0008; ng = 1/0/0.
- Backpressure: 4 back-to-back ops with out_ready=0 from cycle 1 → in_ready=0 after 2 accepts and out held stable; after out_ready=1, all 4 results delivered in order with no duplicates.
- Reset mid-stream with 2 ops in flight → out_valid falls asynchronously; no result emitted after release. Then all 18 table codes × the four {0,FFFF} operand corners, plus 100 random bundles, match the reference model.

Source files
------------

// File: rtl/hack_alu_pkg.sv
// Shared constants for the pipelined Hack ALU: ctrl bit positions,
// shift selector encoding and the canonical Hack computation codes.
package hack_alu_pkg;

    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    typedef enum logic [1:0] {
        EXT_NONE = 2'b00,
        EXT_SHL  = 2'b01,
        EXT_SRA  = 2'b10,
        EXT_SRL  = 2'b11
    } ext_op_e;

    localparam logic [5:0] C_ZERO = 6'b101010;
    localparam logic [5:0] C_ONE  = 6'b111111;
    localparam logic [5:0] C_NEG1 = 6'b111010;
    localparam logic [5:0] C_X    = 6'b001100;
    localparam logic [5:0] C_Y    = 6'b110000;
    localparam logic [5:0] C_NOTX = 6'b001101;
    localparam logic [5:0] C_NOTY = 6'b110001;
    localparam logic [5:0] C_NEGX = 6'b001111;
    localparam logic [5:0] C_NEGY = 6'b110011;
    localparam logic [5:0] C_XP1  = 6'b011111;
    localparam logic [5:0] C_YP1  = 6'b110111;
    localparam logic [5:0] C_XM1  = 6'b001110;
    localparam logic [5:0] C_YM1  = 6'b110010;
    localparam logic [5:0] C_ADD  = 6'b000010;
    localparam logic [5:0] C_XMY  = 6'b010011;
    localparam logic [5:0] C_YMX  = 6'b000111;
    localparam logic [5:0] C_AND  = 6'b000000;
    localparam logic [5:0] C_OR   = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational back half of the Hack ALU: f/no, optional 1-bit shift,
// and zero/negative/overflow flags on pre-processed operands.
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] xp_i,
    input  logic [WIDTH-1:0] yp_i,
    input  logic             f_i,
    input  logic             no_i,
    input  ext_op_e          ext_i,
    output logic [WIDTH-1:0] r_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic             ov_o
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] fn;
    logic [WIDTH-1:0] inv;

    assign sum = xp_i + yp_i;
    assign fn  = f_i ? sum : (xp_i & yp_i);
    assign inv = no_i ? ~fn : fn;

    always_comb begin
        r_o = inv;
        unique case (ext_i)
            EXT_NONE: r_o = inv;
            EXT_SHL:  r_o = {inv[WIDTH-2:0], 1'b0};
            EXT_SRA:  r_o = {inv[WIDTH-1], inv[WIDTH-1:1]};
            EXT_SRL:  r_o = {1'b0, inv[WIDTH-1:1]};
        endcase
    end

    assign zr_o = (r_o == '0);
    assign ng_o = r_o[WIDTH-1];
    // Overflow looks at the raw sum, before inversion or shifting.
    assign ov_o = f_i && (xp_i[WIDTH-1] == yp_i[WIDTH-1])
               && (sum[WIDTH-1] != xp_i[WIDTH-1]);

endmodule

// File: rtl/hack_alu_pipe.sv
// Elastic valid/ready wrapper around hack_alu_core with one or two
// register stages; owns every register and handshake.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter bit EXT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic [1:0]       ext_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             ov
);

    logic [WIDTH-1:0] xp_d, yp_d;
    ext_op_e          ext_d;

    assign xp_d  = (ctrl[ZX] ? '0 : x) ^ {WIDTH{ctrl[NX]}};
    assign yp_d  = (ctrl[ZY] ? '0 : y) ^ {WIDTH{ctrl[NY]}};
    assign ext_d = EXT_EN ? ext_op_e'(ext_op) : EXT_NONE;

    logic             vo_q;
    logic             adv_o;
    logic             sv;
    logic [WIDTH-1:0] cxp, cyp;
    logic             cf, cno;
    ext_op_e          cext;

    assign adv_o = !vo_q || out_ready;

    if (STAGES == 2) begin : g_two
        logic             v1_q;
        logic [WIDTH-1:0] xp_q, yp_q;
        logic             f_q, no_q;
        ext_op_e          ext_q;

        assign in_ready = !v1_q || adv_o;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q  <= 1'b0;
                xp_q  <= '0;
                yp_q  <= '0;
                f_q   <= 1'b0;
                no_q  <= 1'b0;
                ext_q <= EXT_NONE;
            end else if (in_ready) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    xp_q  <= xp_d;
                    yp_q  <= yp_d;
                    f_q   <= ctrl[F];
                    no_q  <= ctrl[NO];
                    ext_q <= ext_d;
                end
            end
        end

        assign sv   = v1_q;
        assign cxp  = xp_q;
        assign cyp  = yp_q;
        assign cf   = f_q;
        assign cno  = no_q;
        assign cext = ext_q;
    end else begin : g_one
        assign in_ready = adv_o;
        assign sv       = in_valid;
        assign cxp      = xp_d;
        assign cyp      = yp_d;
        assign cf       = ctrl[F];
        assign cno      = ctrl[NO];
        assign cext     = ext_d;
    end

    logic [WIDTH-1:0] r_d;
    logic             zr_d, ng_d, ov_d;

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .xp_i  (cxp),
        .yp_i  (cyp),
        .f_i   (cf),
        .no_i  (cno),
        .ext_i (cext),
        .r_o   (r_d),
        .zr_o  (zr_d),
        .ng_o  (ng_d),
        .ov_o  (ov_d)
    );

    logic [WIDTH-1:0] out_q;
    logic             zr_q, ng_q, ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q  <= 1'b0;
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (adv_o) begin
            vo_q <= sv;
            if (sv) begin
                out_q <= r_d;
                zr_q  <= zr_d;
                ng_q  <= ng_d;
                ov_q  <= ov_d;
            end
        end
    end

    assign out_valid = vo_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed and model-checked bench for hack_alu_pipe at
// WIDTH=16, STAGES=2, EXT_EN=1.
module tb_hack_alu_pipe;
    import hack_alu_pkg::*;

    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        ov;
    } res_t;

    typedef struct {
        logic [5:0]  c;
        logic [1:0]  e;
        logic [15:0] a;
        logic [15:0] b;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [5:0]  ctrl = '0;
    logic [1:0]  ext_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        zr, ng, ov;

    int   checks = 0;
    int   failures = 0;
    bit   rand_bp = 0;
    res_t exp_q[$];
    bit   prev_stall = 0;
    res_t prev;

    hack_alu_pipe #(.WIDTH(16), .STAGES(2), .EXT_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .ext_op    (ext_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .ov        (ov)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [5:0] c, input logic [1:0] e,
                                   input logic [15:0] a, input logic [15:0] b);
        logic [15:0] xp, yp, s, r;
        res_t o;
        xp = c[5] ? 16'h0 : a;
        if (c[4]) xp = ~xp;
        yp = c[3] ? 16'h0 : b;
        if (c[2]) yp = ~yp;
        s = xp + yp;
        r = c[1] ? s : (xp & yp);
        if (c[0]) r = ~r;
        case (e)
            2'b01:   r = r << 1;
            2'b10:   r = $signed(r) >>> 1;
            2'b11:   r = r >> 1;
            default: r = r;
        endcase
        o.out = r;
        o.zr  = (r == 16'h0);
        o.ng  = r[15];
        o.ov  = c[1] && (xp[15] == yp[15]) && (s[15] != xp[15]);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_res", 32'({out, zr, ng, ov}), 32'(prev));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got=%h want=none", out);
                end else begin
                    res_t w;
                    w = exp_q.pop_front();
                    if ({out, zr, ng, ov} !== w) begin
                        failures++;
                        $display("FAIL result got out=%h zr=%b ng=%b ov=%b want out=%h zr=%b ng=%b ov=%b",
                                 out, zr, ng, ov, w.out, w.zr, w.ng, w.ov);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = {out, zr, ng, ov};
        end
    end

    task automatic send(input logic [5:0] c, input logic [1:0] e,
                        input logic [15:0] a, input logic [15:0] b, input res_t w);
        bit acc = 0;
        in_valid = 1'b1;
        ctrl = c;
        ext_op = e;
        x = a;
        y = b;
        for (int i = 0; i < 64 && !acc; i++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc) exp_q.push_back(w);
        else begin
            failures++;
            $display("FAIL send_timeout got=stalled want=accept");
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_bp = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
    endtask

    vec_t tbl[13];
    logic [5:0] codes[18];
    logic [15:0] corner[2];

    initial begin
        res_t ea;
        tbl[0]  = '{C_ADD,  2'b00, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b1, 1'b1}};
        tbl[1]  = '{C_XMY,  2'b00, 16'h0005, 16'h0005, '{16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[2]  = '{C_OR,   2'b00, 16'hFFFF, 16'h0000, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
        tbl[3]  = '{C_Y,    2'b10, 16'h1234, 16'h8004, '{16'hC002, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{C_Y,    2'b11, 16'h1234, 16'h8004, '{16'h4002, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{C_Y,    2'b01, 16'h1234, 16'h8004, '{16'h0008, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{C_NEGX, 2'b00, 16'h0001, 16'h0000, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
        tbl[7]  = '{C_XM1,  2'b00, 16'h8000, 16'h0000, '{16'h7FFF, 1'b0, 1'b0, 1'b1}};
        tbl[8]  = '{C_YMX,  2'b00, 16'h0003, 16'h000A, '{16'h0007, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{C_AND,  2'b00, 16'hF0F0, 16'hFF00, '{16'hF000, 1'b0, 1'b1, 1'b0}};
        tbl[10] = '{C_ZERO, 2'b00, 16'h1234, 16'h5678, '{16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[11] = '{C_ONE,  2'b00, 16'h1234, 16'h5678, '{16'h0001, 1'b0, 1'b0, 1'b0}};
        tbl[12] = '{C_ADD,  2'b01, 16'h4000, 16'h4000, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        codes = '{C_ZERO, C_ONE, C_NEG1, C_X, C_Y, C_NOTX, C_NOTY, C_NEGX, C_NEGY,
                  C_XP1, C_YP1, C_XM1, C_YM1, C_ADD, C_XMY, C_YMX, C_AND, C_OR};
        corner = '{16'h0000, 16'hFFFF};

        // reset held with in_valid asserted
        in_valid = 1'b1;
        ctrl = C_ONE;
        x = 16'h1111;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_zr", 32'(zr), 32'd0);
        chk("rst_ng", 32'(ng), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // latency: two cycles from accept
        send(C_X, 2'b00, 16'h1234, 16'h0, '{16'h1234, 1'b0, 1'b0, 1'b0});
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        // directed table, back to back
        foreach (tbl[i]) send(tbl[i].c, tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].exp);
        drain();

        // backpressure: capacity two, output held, in-order release
        out_ready = 1'b0;
        ea = model(C_ADD, 2'b00, 16'h0010, 16'h0020);
        send(C_ADD, 2'b00, 16'h0010, 16'h0020, ea);
        send(C_XMY, 2'b00, 16'h0009, 16'h0004, model(C_XMY, 2'b00, 16'h0009, 16'h0004));
        ctrl = C_NOTX;
        x = 16'h00FF;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out", 32'(out), 32'(ea.out));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready2", 32'(in_ready), 32'd0);
        chk("bp_out2", 32'(out), 32'(ea.out));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(C_NOTX, 2'b00, 16'h00FF, 16'h0, model(C_NOTX, 2'b00, 16'h00FF, 16'h0));
        send(C_YP1, 2'b10, 16'h0, 16'h7FFF, model(C_YP1, 2'b10, 16'h0, 16'h7FFF));
        drain();

        // reset with two bundles in flight
        out_ready = 1'b0;
        send(C_ONE, 2'b00, 16'h0, 16'h0, model(C_ONE, 2'b00, 16'h0, 16'h0));
        send(C_NEG1, 2'b00, 16'h0, 16'h0, model(C_NEG1, 2'b00, 16'h0, 16'h0));
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        chk("mid_async_out", 32'({out, zr, ng, ov}), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_post_valid", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_no_emit", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // all canonical codes over operand corners
        foreach (codes[i])
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    send(codes[i], 2'(i + a), corner[a], corner[b],
                         model(codes[i], 2'(i + a), corner[a], corner[b]));
        drain();

        // random bundles under random backpressure
        rand_bp = 1;
        for (int i = 0; i < 100; i++) begin
            logic [5:0]  c;
            logic [1:0]  e;
            logic [15:0] a, b;
            c = 6'($urandom);
            e = 2'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            send(c, e, a, b, model(c, e, a, b));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
